// File: rtl/chan_mux_scanner.sv
// N-channel registered selector with manual load and round-robin auto-scan.
// Output data is tagged with its source channel plus switch/error pulses.
module chan_mux_scanner #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 2,
   parameter int DWELL_W = 8,
   localparam int SEL_W  = (NUM_CH < 3) ? 1 : $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_ena,
   input  logic [NUM_CH*DATA_W-1:0] i_data_in,
   input  logic                     i_mode,
   input  logic [SEL_W-1:0]         i_sel_in,
   input  logic                     i_sel_load,
   input  logic                     i_hold,
   input  logic [DWELL_W-1:0]       i_dwell,
   output logic [DATA_W-1:0]        o_data_out,
   output logic [SEL_W-1:0]         o_ch_out,
   output logic                     o_switch_pulse,
   output logic                     o_err_pulse
);

   logic [SEL_W-1:0]   r_cur_ch;
   logic [DWELL_W-1:0] r_cnt;
   logic               r_prev_mode;
   logic [DATA_W-1:0]  r_data_out;
   logic [SEL_W-1:0]   r_ch_out;
   logic               r_switch_pulse;
   logic               r_err_pulse;

   logic [31:0]        w_sel_ext;
   logic               w_sel_valid;
   logic [DWELL_W-1:0] w_dwell_eff;
   logic [SEL_W-1:0]   w_next_rr;
   logic [SEL_W-1:0]   w_nxt_ch;
   logic [DWELL_W-1:0] w_nxt_cnt;
   logic               w_nxt_err;
   logic [DATA_W-1:0]  w_sel_data;

   assign w_sel_ext   = 32'(i_sel_in);
   assign w_sel_valid = (w_sel_ext < 32'(NUM_CH));
   assign w_dwell_eff = (i_dwell == {DWELL_W{1'b0}}) ? DWELL_W'(1) : i_dwell;
   assign w_next_rr   = (r_cur_ch == SEL_W'(NUM_CH - 1)) ? {SEL_W{1'b0}} : r_cur_ch + SEL_W'(1);
   assign w_sel_data  = i_data_in[r_cur_ch*DATA_W +: DATA_W];

   // Next channel/counter: load beats mode-entry clear, which beats hold and dwell advance
   always_comb begin
      w_nxt_ch  = r_cur_ch;
      w_nxt_cnt = r_cnt;
      w_nxt_err = 1'b0;
      if (i_sel_load) begin
         if (w_sel_valid) begin
            w_nxt_ch  = i_sel_in;
            w_nxt_cnt = {DWELL_W{1'b0}};
         end else begin
            w_nxt_err = 1'b1;
         end
      end else if (!i_mode || !r_prev_mode) begin
         w_nxt_cnt = {DWELL_W{1'b0}};
      end else if (i_hold) begin
         w_nxt_cnt = r_cnt;
      end else if (r_cnt >= w_dwell_eff - DWELL_W'(1)) begin
         w_nxt_ch  = w_next_rr;
         w_nxt_cnt = {DWELL_W{1'b0}};
      end else begin
         w_nxt_cnt = r_cnt + DWELL_W'(1);
      end
   end

   // State and registered outputs; everything holds while i_ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_ch       <= {SEL_W{1'b0}};
         r_cnt          <= {DWELL_W{1'b0}};
         r_prev_mode    <= 1'b0;
         r_data_out     <= {DATA_W{1'b0}};
         r_ch_out       <= {SEL_W{1'b0}};
         r_switch_pulse <= 1'b0;
         r_err_pulse    <= 1'b0;
      end else if (i_ena) begin
         r_cur_ch       <= w_nxt_ch;
         r_cnt          <= w_nxt_cnt;
         r_prev_mode    <= i_mode;
         r_data_out     <= w_sel_data;
         r_ch_out       <= r_cur_ch;
         r_switch_pulse <= (r_cur_ch != r_ch_out);
         r_err_pulse    <= w_nxt_err;
      end
   end

   assign o_data_out     = r_data_out;
   assign o_ch_out       = r_ch_out;
   assign o_switch_pulse = r_switch_pulse;
   assign o_err_pulse    = r_err_pulse;

endmodule

// File: tb/tb_chan_mux_scanner.sv
// Bench for chan_mux_scanner: a 4-channel and a 3-channel instance share stimulus,
// a per-cycle reference model plus hand-computed literal checks.
module tb_chan_mux_scanner;

   localparam logic [7:0] DATA_DEF = 8'b11_10_01_00;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] data_in;
   logic       mode;
   logic [1:0] sel_in;
   logic       sel_load;
   logic       hold;
   logic [7:0] dwell;

   logic [1:0] dout4, ch4, dout3, ch3;
   logic       sw4, err4, sw3, err3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   chan_mux_scanner #(.NUM_CH(4), .DATA_W(2), .DWELL_W(8)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_data_in(data_in), .i_mode(mode),
      .i_sel_in(sel_in), .i_sel_load(sel_load), .i_hold(hold), .i_dwell(dwell),
      .o_data_out(dout4), .o_ch_out(ch4), .o_switch_pulse(sw4), .o_err_pulse(err4));

   chan_mux_scanner #(.NUM_CH(3), .DATA_W(2), .DWELL_W(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_data_in(data_in[5:0]), .i_mode(mode),
      .i_sel_in(sel_in), .i_sel_load(sel_load), .i_hold(hold), .i_dwell(dwell),
      .o_data_out(dout3), .o_ch_out(ch3), .o_switch_pulse(sw3), .o_err_pulse(err3));

   // Reference model: channel shown, cycles spent on it, visible outputs
   int nch[2] = '{4, 3};
   int m_ch[2], m_age[2], m_pm[2], m_dout[2], m_chout[2], m_sw[2], m_err[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_ch[k] = 0; m_age[k] = 0; m_pm[k] = 0;
            m_dout[k] = 0; m_chout[k] = 0; m_sw[k] = 0; m_err[k] = 0;
         end
      end else if (ena) begin
         for (int k = 0; k < 2; k++) begin
            int d;
            d = (dwell == 8'd0) ? 1 : int'(dwell);
            m_dout[k]  = int'((data_in >> (2 * m_ch[k])) & 8'd3);
            m_sw[k]    = (m_ch[k] != m_chout[k]) ? 1 : 0;
            m_chout[k] = m_ch[k];
            m_err[k]   = (sel_load && int'(sel_in) >= nch[k]) ? 1 : 0;
            if (sel_load) begin
               if (int'(sel_in) < nch[k]) begin
                  m_ch[k] = int'(sel_in);
                  m_age[k] = 0;
               end
            end else if (!mode || m_pm[k] == 0) begin
               m_age[k] = 0;
            end else if (!hold) begin
               m_age[k] = m_age[k] + 1;
               if (m_age[k] >= d) begin
                  m_ch[k] = (m_ch[k] + 1) % nch[k];
                  m_age[k] = 0;
               end
            end
            m_pm[k] = mode ? 1 : 0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("m4_data", int'(dout4), m_dout[0]);
      chk("m4_ch",   int'(ch4),   m_chout[0]);
      chk("m4_sw",   int'(sw4),   m_sw[0]);
      chk("m4_err",  int'(err4),  m_err[0]);
      chk("m3_data", int'(dout3), m_dout[1]);
      chk("m3_ch",   int'(ch3),   m_chout[1]);
      chk("m3_sw",   int'(sw3),   m_sw[1]);
      chk("m3_err",  int'(err3),  m_err[1]);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int exp3[14] = '{0,0,0,0,1,1,1,2,2,2,3,3,3,0};
   int exp0[4]  = '{0,1,2,3};
   int exp4[12] = '{0,0,0,1,1,1,1,1,1,1,1,2};
   int exp5[4]  = '{0,0,0,1};
   int exp6[6]  = '{0,0,0,1,1,2};
   int sw_cnt;

   initial begin
      rst_n = 1'b0; ena = 1'b1; data_in = DATA_DEF; mode = 1'b0;
      sel_in = 2'd0; sel_load = 1'b0; hold = 1'b0; dwell = 8'd3;

      // 1: reset and manual idle
      step(2);
      chk("rst_data", int'(dout4), 0);
      chk("rst_ch", int'(ch4), 0);
      rst_n = 1'b1;
      step(3);
      chk("idle_data", int'(dout4), 0);
      chk("idle_ch", int'(ch4), 0);
      chk("idle_sw", int'(sw4), 0);
      chk("idle_err", int'(err4), 0);

      // 2: manual load of channel 2, then live data change
      sel_in = 2'd2; sel_load = 1'b1;
      step(1);
      sel_load = 1'b0;
      chk("ld_ch_lat1", int'(ch4), 0);
      step(1);
      chk("ld_data", int'(dout4), 2);
      chk("ld_ch", int'(ch4), 2);
      chk("ld_sw", int'(sw4), 1);
      step(1);
      chk("ld_sw_off", int'(sw4), 0);
      data_in = 8'b11_01_01_00;
      step(1);
      chk("live_data", int'(dout4), 1);

      // 3: scan with dwell 3 from channel 0, then dwell 0
      data_in = DATA_DEF;
      sel_in = 2'd0; sel_load = 1'b1;
      step(1);
      sel_load = 1'b0;
      step(2);
      mode = 1'b1;
      sw_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         step(1);
         chk("scan3_ch", int'(ch4), exp3[i]);
         sw_cnt += int'(sw4);
      end
      chk("scan3_sw_count", sw_cnt, 4);
      dwell = 8'd0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("scan0_ch", int'(ch4), exp0[i]);
      end

      // 4: hold for five cycles on channel 1 at count 1, then ena low
      dwell = 8'd3;
      for (int i = 0; i < 12; i++) begin
         hold = (i >= 4 && i <= 8);
         step(1);
         chk("hold_ch", int'(ch4), exp4[i]);
      end
      hold = 1'b0;
      ena = 1'b0;
      step(4);
      chk("frz_data", int'(dout4), 2);
      chk("frz_ch", int'(ch4), 2);
      chk("frz_sw", int'(sw4), 1);
      chk("frz_err", int'(err4), 0);
      ena = 1'b1;

      // 5: load beats an expiring dwell on channel 2
      step(1);
      sel_in = 2'd0; sel_load = 1'b1;
      step(1);
      sel_load = 1'b0;
      chk("pri_ch_before", int'(ch4), 2);
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("pri_ch", int'(ch4), exp5[i]);
      end

      // 5b: out-of-range index on the 3-channel instance
      mode = 1'b0;
      sel_in = 2'd1; sel_load = 1'b1;
      step(1);
      sel_load = 1'b0;
      step(2);
      chk("r3_ch_pre", int'(ch3), 1);
      sel_in = 2'd3; sel_load = 1'b1;
      step(1);
      sel_load = 1'b0;
      chk("r3_err", int'(err3), 1);
      chk("r4_noerr", int'(err4), 0);
      step(1);
      chk("r3_err_off", int'(err3), 0);
      chk("r3_ch_kept", int'(ch3), 1);
      chk("r4_ch3", int'(ch4), 3);
      step(1);
      chk("r3_ch_kept2", int'(ch3), 1);

      // 6: asynchronous reset mid-dwell on channel 3
      mode = 1'b1;
      step(2);
      chk("pre_rst_data", int'(dout4), 3);
      chk("pre_rst_ch", int'(ch4), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_data", int'(dout4), 0);
      chk("arst_ch", int'(ch4), 0);
      chk("arst_sw", int'(sw4), 0);
      chk("arst_err", int'(err4), 0);
      dwell = 8'd2;
      step(1);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("post_rst_ch", int'(ch4), exp6[i]);
      end

      step(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/chan_mux_scanner.md
Name: chan_mux_scanner

Overview:
- Parametrised N-channel, W-bit-wide registered selector.
- Successor to the single-bit 2:1 combinational select used in the tt_um top; it sits between the top's ui_in/uio_in pins and uo_out.
- Two modes. Manual: the channel is loaded by a strobe. Auto-scan: round-robin advance after a programmable dwell time.
- Output data is tagged with its source channel and a switch pulse, so downstream logic knows which channel it is seeing.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 2, bits per channel.
- DWELL_W, 8, width of the dwell-time input and dwell counter.
- SEL_W, derived as max(1, clog2(NUM_CH)), channel index width. Not user-set.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; low means every register holds its value
- data_in  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- mode  in  1  0 = manual, 1 = auto-scan
- sel_in  in  SEL_W  channel index for a manual load
- sel_load  in  1  one-cycle strobe that loads sel_in (honoured in both modes)
- hold  in  1  auto-scan only: freeze the dwell counter and the channel
- dwell  in  DWELL_W  cycles per channel in scan; 0 is treated as 1
- data_out  out  DATA_W  registered data from the selected channel
- ch_out  out  SEL_W  channel index that produced the current data_out
- switch_pulse  out  1  high for one cycle when ch_out changes
- err_pulse  out  1  high for one cycle when sel_load carries an out-of-range index

Behaviour:
- Reset (async, rst_n=0):
  - cur_ch=0, dwell counter cnt=0.
  - data_out=0, ch_out=0, switch_pulse=0, err_pulse=0.
  - prev_mode=0.
- All state updates occur only on posedge clk with ena=1. With ena=0, outputs and state hold; pulses hold their value.
- Datapath, every enabled cycle:
  - data_out <= data_in[cur_ch*DATA_W +: DATA_W]
  - ch_out <= cur_ch
  - Latency: one cycle from cur_ch, two cycles from sel_load to data_out/ch_out of the new channel.
  - data_in changes on the selected channel appear on data_out one cycle later.
- switch_pulse <= (cur_ch != ch_out); it is high in the cycle after ch_out takes the new value, i.e. aligned with the first... [see below].
  - Correction, binding rule: switch_pulse is registered as (cur_ch != ch_out) at the same edge ch_out updates. It is therefore high in exactly the first cycle data_out shows the new channel.
- Manual load, either mode:
  - sel_load=1 and sel_in<NUM_CH: cur_ch <= sel_in, cnt <= 0.
  - sel_load=1 and sel_in>=NUM_CH: cur_ch and cnt unchanged, err_pulse=1 next cycle.
  - err_pulse is otherwise 0.
  - Loading the already-selected channel clears cnt and gives no switch_pulse.
- Auto-scan (mode=1, no sel_load):
  - Effective dwell D = (dwell==0) ? 1 : dwell.
  - hold=1: cnt and cur_ch unchanged.
  - Otherwise, if cnt >= D-1: cnt <= 0 and cur_ch <= (cur_ch==NUM_CH-1) ? 0 : cur_ch+1.
  - Otherwise cnt <= cnt+1.
  - Each channel is therefore shown for exactly D cycles.
- dwell is sampled live. If it is lowered below cnt+1, the channel advances at the next enabled edge (>= compare). There is no counter overflow.
- Mode changes:
  - Mode 0->1 (detected via prev_mode): cnt <= 0, cur_ch unchanged. The first channel in scan gets a full D cycles.
  - Manual mode (mode=0): cnt held at 0, channel changes only via sel_load.
- Priority, highest first: reset > ena=0 > sel_load (valid or invalid) > mode-entry clear > hold > dwell advance.
  - Invalid sel_load also blocks the dwell advance for that cycle.
  - Invalid sel_load does not clear cnt.
- Reset mid-scan returns immediately to channel 0, manual-style idle state. Scanning resumes from 0 after release if mode=1.

Test Plan (NUM_CH=4, DATA_W=2, DWELL_W=8; data_in = {ch3=3, ch2=2, ch1=1, ch0=0} unless stated):
1. Reset, then release with mode=0 and no strobe -> data_out=0, ch_out=0 steadily; switch_pulse and err_pulse stay 0.
2. Manual: sel_in=2 with sel_load for 1 cycle -> two cycles later data_out=2, ch_out=2, switch_pulse=1 for one cycle. Then toggle ch2 data to 1 -> data_out=1 one cycle later.
3. Scan with dwell=3 -> ch_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 (wrap); switch_pulse on each change. dwell=0 -> channel advances every cycle.
4. Scan with hold asserted for 5 cycles at cnt=1 on ch1 -> ch1 held 5 extra cycles, then finishes its remaining 2 dwell cycles. Also assert ena=0 for 4 cycles -> all outputs frozen.
5. Scan: sel_load sel_in=0 in the same cycle dwell expires on ch2 -> cur_ch=0 (not 3), cnt=0, ch0 shown for a full 3 cycles. Repeat with NUM_CH=3 and sel_in=3 -> err_pulse=1 for one cycle, channel unchanged.
6. Assert rst_n low asynchronously mid-dwell on ch3 -> outputs 0 immediately without waiting for a clock edge. After release with mode=1, dwell=2 -> sequence 0,0,1,1...
